// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic arithmetic core: FSM states,
// mode encodings, maximal-length LFSR tap masks and a width-aware bit reverse.
package stoch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_ADD = 1'b1;

   // Fibonacci tap masks (bit t-1 set for tap t), maximal length for 4..16.
   function automatic logic [15:0] lfsr_taps(input int width);
      case (width)
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0829;
         13:      return 16'h100D;
         14:      return 16'h2015;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

   // Reverses the low 'width' bits of value; upper result bits are zero.
   function automatic logic [15:0] bitrev(input logic [15:0] value, input int width);
      logic [15:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < width) r[i] = value[width-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous load of the seed and a step
// enable. A zero seed would lock the register, so it is replaced by 1.
module stoch_lfsr
   import stoch_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEED  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   output logic [WIDTH-1:0] value_o
);

   localparam logic [15:0]      TAPS16   = lfsr_taps(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAPS16[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED_RAW = WIDTH'(SEED);
   localparam logic [WIDTH-1:0] SEED_EFF = (SEED_RAW == '0) ? WIDTH'(1) : SEED_RAW;

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;
   logic             fb;

   always_comb begin
      fb     = ^(lfsr_q & TAPS);
      lfsr_d = lfsr_q;
      if (load_i) begin
         lfsr_d = SEED_EFF;
      end else if (step_i) begin
         lfsr_d = {lfsr_q[WIDTH-2:0], fb};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr_q <= SEED_EFF;
      else     lfsr_q <= lfsr_d;
   end

   assign value_o = lfsr_q;

endmodule

// File: rtl/stoch_arith_core.sv
// Stochastic multiply / scaled-add engine: LFSR-driven unipolar streams, AND or
// toggle-MUX combine, popcount back to binary. STOCH_DBG_STREAM_EN adds stream_o.
module stoch_arith_core
   import stoch_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEED  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o
`ifdef STOCH_DBG_STREAM_EN
   ,
   output logic [2:0]       stream_o
`endif
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'((1 << WIDTH) - 2);

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             mode_q;
   logic             toggle_q;
   logic [WIDTH-1:0] acc_q, cnt_q, result_q;
   logic             busy_q, done_q;

   logic [WIDTH-1:0] r;
   logic [15:0]      rr16;
   logic             sa, sb, out_bit;
   logic             lfsr_load, lfsr_step;

   assign lfsr_load = (state_q == IDLE) && start_i;
   assign lfsr_step = (state_q == RUN);

   stoch_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .load_i (lfsr_load),
      .step_i (lfsr_step),
      .value_o(r)
   );

   // Comparing the reversed value against B decorrelates the two streams.
   always_comb begin
      rr16    = bitrev(16'(r), WIDTH);
      sa      = (r <= a_q);
      sb      = (rr16 <= 16'(b_q));
      out_bit = (mode_q == MODE_ADD) ? (toggle_q ? sb : sa) : (sa & sb);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= MODE_MUL;
         toggle_q <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  a_q      <= a_i;
                  b_q      <= b_i;
                  mode_q   <= mode_i;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  toggle_q <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               acc_q    <= acc_q + WIDTH'(out_bit);
               cnt_q    <= cnt_q + WIDTH'(1);
               toggle_q <= ~toggle_q;
               if (cnt_q == LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE: begin
               result_q <= acc_q;
               done_q   <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

`ifdef STOCH_DBG_STREAM_EN
   assign stream_o = busy_q ? {out_bit, sb, sa} : 3'b000;
`endif

endmodule

// File: tb/tb_stoch_arith_core.sv
// Self-checking bench for stoch_arith_core: directed corner cases plus a random
// sweep checked against a stream-level reference model (supports WIDTH 4 and 8).
module tb_stoch_arith_core;

   parameter int WIDTH = 8;
   localparam int L     = (1 << WIDTH) - 1;
   localparam int SEED  = 1;
   localparam int MUL   = 0;
   localparam int ADD   = 1;
   localparam int N_RND = (WIDTH <= 6) ? 500 : 150;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic             mode_i;
   logic [WIDTH-1:0] a_i, b_i;
   logic             busy_o, done_o;
   logic [WIDTH-1:0] result_o;
`ifdef STOCH_DBG_STREAM_EN
   logic [2:0]       stream_o;
   int               dbg_ones = 0;
`endif

   stoch_arith_core #(.WIDTH(WIDTH), .SEED(SEED)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .mode_i  (mode_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .result_o(result_o)
`ifdef STOCH_DBG_STREAM_EN
      ,
      .stream_o(stream_o)
`endif
   );

   always #5 clk = ~clk;

`ifdef STOCH_DBG_STREAM_EN
   always @(negedge clk) if (busy_o) dbg_ones <= dbg_ones + int'(stream_o[0]);
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int max_add_err = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Primitive feedback polynomials: x^4+x^3+1 and x^8+x^6+x^5+x^4+1.
   function automatic int poly_mask(input int w);
      if (w == 4) return 'hC;
      return 'hB8;
   endfunction

   function automatic int next_state(input int r);
      int p;
      p = $countones(r & poly_mask(WIDTH)) & 1;
      return ((r << 1) | p) & L;
   endfunction

   function automatic int rev(input int v);
      int r = 0;
      for (int i = 0; i < WIDTH; i++) if ((v >> i) & 1) r |= 1 << (WIDTH - 1 - i);
      return r;
   endfunction

   // Ones in the output stream over one full sweep of the generator states.
   function automatic int model(input int mode, input int a, input int b);
      int r = SEED, cnt = 0, tog = 0;
      bit sa, sb;
      for (int k = 0; k < L; k++) begin
         sa = (r <= a);
         sb = (rev(r) <= b);
         if (mode == MUL) cnt += int'(sa & sb);
         else             cnt += int'(tog ? sb : sa);
         tog ^= 1;
         r = next_state(r);
      end
      return cnt;
   endfunction

   task automatic run_op(input int mode, input int a, input int b, input int poke_at,
                         output int res);
      int lat = 0, busy = 0;
      bit got_done = 0;
      @(negedge clk);
`ifdef STOCH_DBG_STREAM_EN
      dbg_ones = 0;
`endif
      mode_i  = mode[0];
      a_i     = WIDTH'(a);
      b_i     = WIDTH'(b);
      start_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      while (lat <= 4 * L + 8) begin
         if (busy_o) busy++;
         if (lat == poke_at) begin
            start_i = 1'b1;
            a_i     = ~a_i;
            b_i     = ~b_i;
            mode_i  = ~mode_i;
         end else if (lat == poke_at + 1) begin
            start_i = 1'b0;
         end
         if (done_o) begin
            got_done = 1;
            break;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start_i = 1'b0;
      res = int'(result_o);
      chk("done_seen", got_done, 1);
      chk("latency", lat, L + 1);
      chk("busy_cycles", busy, L);
      chk("result_no_x", $isunknown(result_o), 0);
`ifdef STOCH_DBG_STREAM_EN
      chk("dbg_popcount_a", dbg_ones, a);
      chk("dbg_idle_zero", stream_o, 0);
`endif
      @(posedge clk);
      @(negedge clk);
      chk("done_one_cycle", done_o, 0);
   endtask

   initial begin
      int res, a, b, m, err, exp_v, cyc, npulse, ndone;
      int pulse_at[3];
      rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; a_i = '0; b_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_result", result_o, 0);
      rst = 1'b0;

      // Encodings that are exact by construction.
      a = (L * 200) / 255;
      run_op(MUL, a, L, -1, res);          chk("mul_a_full_b", res, a);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("result_held", result_o, a);
      run_op(MUL, 0, (L * 173) / 255, -1, res); chk("mul_zero_a", res, 0);
      run_op(MUL, (L * 97) / 255, 0, -1, res);  chk("mul_zero_b", res, 0);
      run_op(MUL, L, L, -1, res);               chk("mul_full", res, L);
      b = (L * 9) / 15;
      run_op(MUL, L, b, -1, res);               chk("mul_full_a", res, b);
      a = (L * 90) / 255;
      run_op(ADD, a, a, -1, res);               chk("add_equal", res, model(ADD, a, a));

      // Start pulse and operand changes mid-run must not disturb the result.
      a = $urandom_range(0, L); b = $urandom_range(0, L);
      run_op(MUL, a, b, L / 2, res);            chk("poke_ignored", res, model(MUL, a, b));

      // Reset in the middle of a run.
      @(negedge clk);
      mode_i = 1'b0; a_i = WIDTH'((L * 200) / 255); b_i = WIDTH'(L); start_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_i = 1'b0;
      repeat ((L * 100) / 255) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_result", result_o, 0);
      chk("abort_busy", busy_o, 0);
      chk("abort_done", done_o, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 2 * L + 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (done_o) ndone++;
      end
      chk("no_stale_done", ndone, 0);
      run_op(MUL, L, L, -1, res);               chk("after_abort", res, L);

      // start_i held high: back-to-back runs.
      a = $urandom_range(0, L); b = $urandom_range(0, L);
      exp_v = model(MUL, a, b);
      @(negedge clk);
      mode_i = 1'b0; a_i = WIDTH'(a); b_i = WIDTH'(b); start_i = 1'b1;
      cyc = 0; npulse = 0;
      while (npulse < 3 && cyc < 4 * (L + 2) + 10) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (done_o) begin
            pulse_at[npulse] = cyc;
            npulse++;
            chk("b2b_result", result_o, exp_v);
         end
      end
      start_i = 1'b0;
      chk("b2b_pulses", npulse, 3);
      chk("b2b_first", pulse_at[0], L + 2);
      chk("b2b_gap1", pulse_at[1] - pulse_at[0], L + 2);
      chk("b2b_gap2", pulse_at[2] - pulse_at[1], L + 2);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("b2b_stopped", busy_o, 0);

      // Random sweep against the stream model and the ideal-value bound.
      for (int n = 0; n < N_RND; n++) begin
         m = int'($urandom_range(0, 1));
         a = $urandom_range(0, L);
         b = $urandom_range(0, L);
         run_op(m, a, b, -1, res);
         chk(m == MUL ? "rnd_mul" : "rnd_add", res, model(m, a, b));
         if (m == MUL) begin
            err = res * L - a * b;
            if (err < 0) err = -err;
            chk("rnd_mul_tol", err <= 6 * L, 1);
         end else begin
            err = 2 * res - (a + b);
            if (err < 0) err = -err;
            if (err > 2 * max_add_err) max_add_err = (err + 1) / 2;
         end
      end
      $display("[TB] info: largest scaled-add deviation from (A+B)/2 was about %0d", max_add_err);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
